fetch_unit: RTL and testbench

Instruction fetch producer for the out-of-order core. Generates sequential PCs, issues reads to a synchronous instruction memory (1-cycle read latency), and drives fetched {pc, instr} pairs onto a valid/ready interface toward decode. Holds up to two fetched instructions, one in the output register and one in a skid entry, so it sustains 1 instr/cycle under full backpressure without dropping memory responses. Squashes all in-flight and buffered work on a redirect.

---
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with a one-entry skid buffer behind the output register.
// Redirect and reset flush all in-flight and buffered work and restart fetch.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        valid_out,
    input  logic        ready_out,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out
);
    logic [31:0] pc_req_q, pc_req_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    logic        inflight_q, inflight_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] instr_out_q, instr_out_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;

    logic       pop;
    logic       out_free;
    logic [1:0] occ;
    logic [1:0] occ_after_pop;

    always_comb begin
        pop           = valid_q && ready_out;
        out_free      = !valid_q || pop;
        occ           = {1'b0, valid_q} + {1'b0, skid_valid_q} + {1'b0, inflight_q};
        occ_after_pop = occ - {1'b0, pop};
        imem_en       = !reset && !redirect_valid && (occ_after_pop < 2'd2);

        pc_req_d     = pc_req_q;
        resp_pc_d    = resp_pc_q;
        inflight_d   = 1'b0;
        valid_d      = valid_q;
        pc_out_d     = pc_out_q;
        instr_out_d  = instr_out_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;

        if (imem_en) begin
            resp_pc_d  = pc_req_q;
            pc_req_d   = pc_req_q + 32'd4;
            inflight_d = 1'b1;
        end

        // Skid entry always drains ahead of a new arrival so issue order is kept.
        if (out_free) begin
            if (skid_valid_q) begin
                valid_d      = 1'b1;
                pc_out_d     = skid_pc_q;
                instr_out_d  = skid_instr_q;
                skid_valid_d = 1'b0;
            end else if (inflight_q) begin
                valid_d     = 1'b1;
                pc_out_d    = resp_pc_q;
                instr_out_d = imem_rdata;
            end else begin
                valid_d = 1'b0;
            end
        end

        if (inflight_q && !(out_free && !skid_valid_q)) begin
            skid_valid_d = 1'b1;
            skid_pc_d    = resp_pc_q;
            skid_instr_d = imem_rdata;
        end

        if (redirect_valid) begin
            pc_req_d     = redirect_pc;
            inflight_d   = 1'b0;
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_req_q     <= RESET_PC;
            inflight_q   <= 1'b0;
            valid_q      <= 1'b0;
            skid_valid_q <= 1'b0;
            pc_out_q     <= 32'd0;
            instr_out_q  <= 32'd0;
        end else begin
            pc_req_q     <= pc_req_d;
            inflight_q   <= inflight_d;
            valid_q      <= valid_d;
            skid_valid_q <= skid_valid_d;
            pc_out_q     <= pc_out_d;
            instr_out_q  <= instr_out_d;
        end
    end

    // Payload-only registers; their contents are qualified by the flags above.
    always_ff @(posedge clk) begin
        resp_pc_q    <= resp_pc_d;
        skid_pc_q    <= skid_pc_d;
        skid_instr_q <= skid_instr_d;
    end

    assign imem_addr = pc_req_q;
    assign valid_out = valid_q;
    assign pc_out    = pc_out_q;
    assign instr_out = instr_out_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: flow, backpressure, redirects, wrap-around RESET_PC, mid-stream reset.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ready_out;

    logic        imem_en, imem_en2;
    logic [31:0] imem_addr, imem_addr2;
    logic [31:0] imem_rdata, imem_rdata2;
    logic        valid_out, valid_out2;
    logic [31:0] pc_out, pc_out2;
    logic [31:0] instr_out, instr_out2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .valid_out(valid_out), .ready_out(ready_out),
        .pc_out(pc_out), .instr_out(instr_out)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_en(imem_en2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .valid_out(valid_out2), .ready_out(ready_out),
        .pc_out(pc_out2), .instr_out(instr_out2)
    );

    // Synchronous instruction memories with 1-cycle read latency.
    always @(posedge clk) begin
        if (imem_en)  imem_rdata  <= imem_addr  ^ 32'hA5A5_0000;
        if (imem_en2) imem_rdata2 <= imem_addr2 ^ 32'hA5A5_0000;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'd0, valid_out}, 32'd1);
        chk({tag, "_pc"}, pc_out, pc);
        chk({tag, "_instr"}, instr_out, pc ^ 32'hA5A5_0000);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; ready_out = 1'b1;
        imem_rdata = 32'd0; imem_rdata2 = 32'd0;
        step(); step();
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_pc", pc_out, 32'd0);
        chk("rst_instr", instr_out, 32'd0);
        chk("rst_en", {31'd0, imem_en}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_addr_wrap", imem_addr2, 32'hFFFF_FFF8);

        reset = 1'b0;
        #1;
        chk("c_en", {31'd0, imem_en}, 32'd1);
        chk("c_addr", imem_addr, 32'd0);
        step();
        chk("c_valid", {31'd0, valid_out}, 32'd0);
        chk("c1_addr", imem_addr, 32'd4);
        step();
        chk_out("flow0", 32'd0);
        chk("wrap0_pc", pc_out2, 32'hFFFF_FFF8);
        chk("wrap0_instr", instr_out2, 32'h5A5A_FFF8);
        step();
        chk_out("flow4", 32'd4);
        chk("wrap1_pc", pc_out2, 32'hFFFF_FFFC);
        chk("wrap1_instr", instr_out2, 32'h5A5A_FFFC);
        step();
        chk_out("flow8", 32'd8);
        chk("wrap2_pc", pc_out2, 32'h0000_0000);

        // Stall: 8 held at the output, 12 lands in the skid entry, 16 never requested.
        ready_out = 1'b0;
        #1;
        chk("stall_en0", {31'd0, imem_en}, 32'd0);
        chk("stall_addr", imem_addr, 32'd16);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out("stall_hold", 32'd8);
            chk("stall_en", {31'd0, imem_en}, 32'd0);
            chk("stall_addr_hold", imem_addr, 32'd16);
        end
        ready_out = 1'b1;
        #1;
        chk("release_en", {31'd0, imem_en}, 32'd1);
        chk("release_addr", imem_addr, 32'd16);
        step();
        chk_out("rel12", 32'd12);
        chk("wrap3_pc", pc_out2, 32'h0000_0004);
        step();
        chk_out("rel16", 32'd16);
        step();
        chk_out("rel20", 32'd20);

        // Redirect with skid full: state is output=20, skid=24.
        ready_out = 1'b0;
        step();
        chk_out("pre_redir_hold", 32'd20);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100; ready_out = 1'b1;
        #1;
        chk("redir_en", {31'd0, imem_en}, 32'd0);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("redir_n_valid", {31'd0, valid_out}, 32'd0);
        chk("redir_n_en", {31'd0, imem_en}, 32'd1);
        chk("redir_n_addr", imem_addr, 32'h0000_0100);
        step();
        chk("redir_n1_valid", {31'd0, valid_out}, 32'd0);
        step();
        chk_out("redir_100", 32'h0000_0100);
        step();
        chk_out("redir_104", 32'h0000_0104);

        // Redirect coinciding with a pop of 0x104; ready toggles afterwards.
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        step();
        redirect_valid = 1'b0; ready_out = 1'b0;
        #1;
        chk("rpop_n_valid", {31'd0, valid_out}, 32'd0);
        step();
        chk("rpop_n1_valid", {31'd0, valid_out}, 32'd0);
        step();
        chk_out("rpop_200", 32'h0000_0200);
        step();
        chk_out("rpop_200_hold", 32'h0000_0200);
        ready_out = 1'b1;
        step();
        chk_out("rpop_204", 32'h0000_0204);

        // Mid-stream reset with the skid entry full.
        ready_out = 1'b0;
        step();
        chk_out("prerst_hold", 32'h0000_0204);
        reset = 1'b1;
        step();
        chk("mrst_valid", {31'd0, valid_out}, 32'd0);
        chk("mrst_en", {31'd0, imem_en}, 32'd0);
        chk("mrst_addr", imem_addr, 32'd0);
        reset = 1'b0; ready_out = 1'b1;
        #1;
        chk("mrst_c_en", {31'd0, imem_en}, 32'd1);
        step();
        chk("mrst_c_valid", {31'd0, valid_out}, 32'd0);
        step();
        chk_out("mrst_0", 32'd0);
        step();
        chk_out("mrst_4", 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
